// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_pkg;

  localparam int unsigned NUM_WB_SRC = 8;
  localparam int unsigned SRC_IDX_W  = 3;

  // Selector value that routes the mux's hardwired stack-pointer constant.
  localparam logic [3:0] SEL_SP_CONST = 4'b1000;

  // Architectural zero register: writes to it are dropped.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A grant only produces a register-file write when it targets a real register.
  function automatic logic writes_reg(input logic [4:0] r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the result sources / control unit and the arbiter.
// Latency: n/a (wires only).
// Backpressure: sources hold req until they see gnt; hold stalls all new grants.
//
// Signals:
//   req[7:0]            source i has a result pending
//   dest[39:0]          dest[5i+4:5i] = destination register of source i
//   hold                control-unit stall
//   gnt[7:0]            one-hot grant, one cycle per accepted request
//   mem_to_reg_sel[3:0] write-back mux selector (bit 3 = SP constant)
//   reg_write           register-file write enable
//   write_reg[4:0]      register-file write address
//   busy                arbiter has INIT pending or unmasked requests
// Modports: master = sources/control side, slave = arbiter side.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic [NUM_WB_SRC-1:0]   req;
  logic [5*NUM_WB_SRC-1:0] dest;
  logic                    hold;
  logic [NUM_WB_SRC-1:0]   gnt;
  logic [3:0]              mem_to_reg_sel;
  logic                    reg_write;
  logic [4:0]              write_reg;
  logic                    busy;

  modport master (
    output req, dest, hold,
    input  gnt, mem_to_reg_sel, reg_write, write_reg, busy
  );

  modport slave (
    input  req, dest, hold,
    output gnt, mem_to_reg_sel, reg_write, write_reg, busy
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational 8-way picker: first set bit of cand searching upward from start, wrapping 7->0.
// Latency: zero (pure combinational).
// Backpressure: none; any=0 when cand is empty.
//
// Ports:
//   cand[7:0]    candidate requesters
//   start[2:0]   index searched first (tied to 0 for fixed priority)
//   any          at least one candidate present
//   win_oh[7:0]  one-hot winner
//   win_idx[2:0] binary winner
module wb_rr_pick
  import wb_pkg::*;
(
  input  logic [NUM_WB_SRC-1:0] cand,
  input  logic [SRC_IDX_W-1:0]  start,
  output logic                  any,
  output logic [NUM_WB_SRC-1:0] win_oh,
  output logic [SRC_IDX_W-1:0]  win_idx
);

  logic [SRC_IDX_W-1:0] idx;

  always_comb begin
    any     = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_WB_SRC; k++) begin
      // 3-bit add wraps naturally from 7 back to 0.
      idx = start + k[SRC_IDX_W-1:0];
      if (!any && cand[idx]) begin
        any         = 1'b1;
        win_idx     = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port sequencer/arbiter: one SP-init write after reset, then one source grant per cycle.
// Latency: req sampled at edge N -> gnt/reg_write/sel/write_reg registered at edge N, write lands at N+1.
// Backpressure: hold or an empty candidate set idles the port; sources keep req high until granted.
//
// Ports:
//   clk    clock, all state on rising edge
//   reset  synchronous active-low reset
//   bus    wb_port_arbiter_if.slave (req/dest/hold in; gnt/sel/reg_write/write_reg/busy out)
// Parameter SP_REG: destination register of the post-reset stack-pointer write.
// Build option: define WB_RR_EN for round-robin; otherwise lowest index wins.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned SP_REG = 29
)
(
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [4:0] SP_REG_W = SP_REG[4:0];

  state_t                state;
  logic [NUM_WB_SRC-1:0] gnt_q;
  logic [3:0]            sel_q;
  logic                  rw_q;
  logic [4:0]            wr_q;

  logic [NUM_WB_SRC-1:0] cand;
  logic [SRC_IDX_W-1:0]  start;
  logic                  any;
  logic [NUM_WB_SRC-1:0] win_oh;
  logic [SRC_IDX_W-1:0]  win_idx;
  logic [4:0]            win_dest;
  logic [4:0]            dest_arr [NUM_WB_SRC];

  // The source granted this cycle still shows req high; mask it so it is not granted twice.
  assign cand = bus.req & ~gnt_q;

`ifdef WB_RR_EN
  logic [SRC_IDX_W-1:0] rr_ptr;
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  for (genvar g = 0; g < NUM_WB_SRC; g++) begin : g_dest
    assign dest_arr[g] = bus.dest[5*g +: 5];
  end

  assign win_dest = dest_arr[win_idx];

  wb_rr_pick u_pick (
    .cand    (cand),
    .start   (start),
    .any     (any),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      gnt_q <= '0;
      sel_q <= '0;
      rw_q  <= 1'b0;
      wr_q  <= REG_ZERO;
`ifdef WB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        INIT: begin
          // Requests are ignored here; this cycle belongs to the SP constant write.
          sel_q <= SEL_SP_CONST;
          wr_q  <= SP_REG_W;
          rw_q  <= 1'b1;
          gnt_q <= '0;
          state <= RUN;
        end
        RUN: begin
          if (bus.hold || !any) begin
            // Selector and address keep their last values on idle cycles.
            gnt_q <= '0;
            rw_q  <= 1'b0;
          end else begin
            gnt_q <= win_oh;
            sel_q <= {1'b0, win_idx};
            wr_q  <= win_dest;
            // A zero-register request is consumed without a write.
            rw_q  <= writes_reg(win_dest);
`ifdef WB_RR_EN
            rr_ptr <= win_idx + 3'd1;
`endif
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.mem_to_reg_sel = sel_q;
  assign bus.reg_write      = rw_q;
  assign bus.write_reg      = wr_q;
  assign bus.busy           = (state == INIT) || (|cand);

endmodule
